regfile_storage: RTL

Storage array for the 32-entry register file: a 5-to-32 write decoder, 32 registers of WIDTH bits and a sequenced bulk-clear engine. It sits directly upstream of the 32:1 by-32 read multiplexers. Its 32 register outputs wire one-to-one onto the mux data inputs; the read-address muxing stays downstream.

---
 rtl/regfile_storage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/regfile_storage.sv
// 32-entry register storage with a write decoder and a sequenced bulk-clear engine.
// Optional macro REG0_HARDWIRED_EN: q0 is constant zero and the clear sweep starts at index 1.
module regfile_storage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             clear_start,
    output logic             busy,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [WIDTH-1:0] q8,
    output logic [WIDTH-1:0] q9,
    output logic [WIDTH-1:0] q10,
    output logic [WIDTH-1:0] q11,
    output logic [WIDTH-1:0] q12,
    output logic [WIDTH-1:0] q13,
    output logic [WIDTH-1:0] q14,
    output logic [WIDTH-1:0] q15,
    output logic [WIDTH-1:0] q16,
    output logic [WIDTH-1:0] q17,
    output logic [WIDTH-1:0] q18,
    output logic [WIDTH-1:0] q19,
    output logic [WIDTH-1:0] q20,
    output logic [WIDTH-1:0] q21,
    output logic [WIDTH-1:0] q22,
    output logic [WIDTH-1:0] q23,
    output logic [WIDTH-1:0] q24,
    output logic [WIDTH-1:0] q25,
    output logic [WIDTH-1:0] q26,
    output logic [WIDTH-1:0] q27,
    output logic [WIDTH-1:0] q28,
    output logic [WIDTH-1:0] q29,
    output logic [WIDTH-1:0] q30,
    output logic [WIDTH-1:0] q31
);

    // state | meaning
    // IDLE  | writes accepted, waiting for clear_start
    // CLEAR | zeroing reg[ptr] each cycle, writes refused
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

`ifdef REG0_HARDWIRED_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    state_t           state;
    state_t           state_next;
    logic [4:0]       ptr;
    logic [4:0]       ptr_next;
    logic [WIDTH-1:0] regs [FIRST:31];

    assign busy     = (state == CLEAR);
    assign wr_ready = !busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 5'd0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next = CLEAR;
                    ptr_next   = 5'(FIRST);
                end
            end
            CLEAR: begin
                ptr_next = ptr + 5'd1;
                if (ptr == 5'd31) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                ptr_next   = 5'd0;
            end
        endcase
    end

    // Clear and write never collide: writes are only accepted while not busy.
    always_ff @(posedge clk) begin
        for (int i = FIRST; i < 32; i++) begin
            if (reset) begin
                regs[i] <= '0;
            end else if (busy && ptr == 5'(i)) begin
                regs[i] <= '0;
            end else if (wr_en && wr_ready && wr_addr == 5'(i)) begin
                regs[i] <= wr_data;
            end
        end
    end

`ifdef REG0_HARDWIRED_EN
    assign q0  = '0;
`else
    assign q0  = regs[0];
`endif
    assign q1  = regs[1];
    assign q2  = regs[2];
    assign q3  = regs[3];
    assign q4  = regs[4];
    assign q5  = regs[5];
    assign q6  = regs[6];
    assign q7  = regs[7];
    assign q8  = regs[8];
    assign q9  = regs[9];
    assign q10 = regs[10];
    assign q11 = regs[11];
    assign q12 = regs[12];
    assign q13 = regs[13];
    assign q14 = regs[14];
    assign q15 = regs[15];
    assign q16 = regs[16];
    assign q17 = regs[17];
    assign q18 = regs[18];
    assign q19 = regs[19];
    assign q20 = regs[20];
    assign q21 = regs[21];
    assign q22 = regs[22];
    assign q23 = regs[23];
    assign q24 = regs[24];
    assign q25 = regs[25];
    assign q26 = regs[26];
    assign q27 = regs[27];
    assign q28 = regs[28];
    assign q29 = regs[29];
    assign q30 = regs[30];
    assign q31 = regs[31];

endmodule
